// File: rtl/mem2axi_pkg.sv
// Purpose: shared types for mem2axi_master (FSM state, AXI4 channel/bundle structs, axsize helper).
// Latency: none, types and constants only.
// Backpressure: none, types and constants only.
package mem2axi_pkg;

  // Widths of the crossbar slave port this block drives
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned USER_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WAIT_B,
    RD,
    WAIT_R
  } state_e;

  // Single-beat transfers always use the full bus width
  function automatic logic [2:0] axsize(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [5:0]        atop;
    logic [USER_W-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
    logic [USER_W-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic [USER_W-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [USER_W-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [USER_W-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } m2a_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } m2a_resp_t;

endpackage

// File: rtl/mem2axi_master.sv
// Purpose: single-outstanding bridge from a req/gnt memory port to single-beat AXI4 reads and writes.
// Latency: grant in cycle 0, AW/W/AR valid in cycle 1, rvalid_o one cycle after the B/R handshake.
// Backpressure: gnt_o only in IDLE; AXI valids held until their own ready, requester holds req_i meanwhile.
module mem2axi_master
  import mem2axi_pkg::*;
#(
  parameter int unsigned                AXI_ADDR_WIDTH = 64,
  parameter int unsigned                AXI_DATA_WIDTH = 64,
  parameter int unsigned                AXI_ID_WIDTH   = 4,
  parameter int unsigned                AXI_USER_WIDTH = 64,
  parameter logic [AXI_ID_WIDTH-1:0]    AXI_ID         = '0,
  parameter type                        axi_req_t      = mem2axi_pkg::m2a_req_t,
  parameter type                        axi_resp_t     = mem2axi_pkg::m2a_resp_t
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_i,
  output logic                          gnt_o,
  input  logic                          we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   be_i,
  input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
  output logic                          rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]     rdata_o,
  output logic                          err_o,
  output axi_req_t                      axi_req_o,
  input  axi_resp_t                     axi_resp_i
);

  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam logic [2:0]  AX_SIZE    = axsize(AXI_DATA_WIDTH);

  state_e                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [STRB_WIDTH-1:0]     be_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic                      aw_valid_q;
  logic                      w_valid_q;
  logic                      ar_valid_q;
  logic                      b_ready_q;
  logic                      r_ready_q;
  logic                      rvalid_q;
  logic                      err_q;
  logic                      aw_done;
  logic                      w_done;

  // Only IDLE grants; the requester keeps req_i asserted while we are busy
  assign gnt_o = (state_q == IDLE) && req_i;

  // A write channel is done once its valid has dropped or its handshake happens this cycle
  assign aw_done = !aw_valid_q || axi_resp_i.aw_ready;
  assign w_done  = !w_valid_q  || axi_resp_i.w_ready;

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  // Transaction FSM with registered AXI handshake outputs and completion flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i;
            be_q    <= be_i;
            wdata_q <= wdata_i;
            if (we_i) begin
              state_q    <= WR;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end else begin
              state_q    <= RD;
              ar_valid_q <= 1'b1;
            end
          end
        end
        WR: begin
          if (axi_resp_i.aw_ready) aw_valid_q <= 1'b0;
          if (axi_resp_i.w_ready)  w_valid_q  <= 1'b0;
          if (aw_done && w_done) begin
            state_q   <= WAIT_B;
            b_ready_q <= 1'b1;
          end
        end
        WAIT_B: begin
          if (axi_resp_i.b_valid) begin
            state_q   <= IDLE;
            b_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            err_q     <= axi_resp_i.b.resp[1];
          end
        end
        RD: begin
          if (axi_resp_i.ar_ready) begin
            state_q    <= WAIT_R;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
          end
        end
        WAIT_R: begin
          if (axi_resp_i.r_valid) begin
            state_q   <= IDLE;
            r_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= axi_resp_i.r.data;
            err_q     <= axi_resp_i.r.resp[1] | ~axi_resp_i.r.last;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Constant single-beat INCR attributes around the held request
  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = AXI_ID;
    axi_req_o.aw.addr  = addr_q;
    axi_req_o.aw.len   = 8'd0;
    axi_req_o.aw.size  = AX_SIZE;
    axi_req_o.aw.burst = BURST_INCR;
    axi_req_o.aw.user  = {AXI_USER_WIDTH{1'b0}};
    axi_req_o.aw_valid = aw_valid_q;
    axi_req_o.w.data   = wdata_q;
    axi_req_o.w.strb   = be_q;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid_q;
    axi_req_o.b_ready  = b_ready_q;
    axi_req_o.ar.id    = AXI_ID;
    axi_req_o.ar.addr  = addr_q;
    axi_req_o.ar.len   = 8'd0;
    axi_req_o.ar.size  = AX_SIZE;
    axi_req_o.ar.burst = BURST_INCR;
    axi_req_o.ar.user  = {AXI_USER_WIDTH{1'b0}};
    axi_req_o.ar_valid = ar_valid_q;
    axi_req_o.r_ready  = r_ready_q;
  end

  // Response IDs and user bits carry no information with a single transaction in flight
  logic unused_resp;
  assign unused_resp = ^{axi_resp_i.b.id, axi_resp_i.b.user, axi_resp_i.b.resp[0],
                         axi_resp_i.r.id, axi_resp_i.r.user, axi_resp_i.r.resp[0]};

endmodule

// File: tb/tb_mem2axi_master.sv
`timescale 1ns/1ps
module tb_mem2axi_master;
  import mem2axi_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [63:0] addr_i;
  logic [7:0]  be_i;
  logic [63:0] wdata_i;
  logic        rvalid_o;
  logic [63:0] rdata_o;
  logic        err_o;
  m2a_req_t    axi_req;
  m2a_resp_t   axi_resp = '0;

  always #5 clk_i = ~clk_i;

  mem2axi_master dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .be_i       (be_i),
    .wdata_i    (wdata_i),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .axi_req_o  (axi_req),
    .axi_resp_i (axi_resp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit mapped(input logic [63:0] a);
    return a >= 64'h8000_0000;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // ---------------- slave environment (crossbar + RAM stand-in) ----------------
  int       aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  bit       r_last_bad = 0;
  int       aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit       aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  bit       aw_wait = 0, w_wait = 0, ar_wait = 0;
  aw_chan_t cap_aw;
  w_chan_t  cap_w;
  ar_chan_t cap_ar;
  logic [1:0]  b_resp_v;
  logic [1:0]  r_resp_v;
  logic [63:0] r_data_v;
  int       w_beats = 0, pulses = 0;
  logic [63:0] slv_mem [logic [60:0]];

  always @(negedge clk_i) begin
    #2;
    if (rst_i) begin
      axi_resp = '0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (rvalid_o) pulses++;
      // B channel
      if (b_pend) begin
        if (b_cnt >= b_delay) begin
          axi_resp.b_valid = 1'b1;
          axi_resp.b.resp  = b_resp_v;
          if (axi_req.b_ready) b_pend = 0;
        end else b_cnt++;
      end else axi_resp.b_valid = 1'b0;
      // R channel
      if (r_pend) begin
        if (r_cnt >= r_delay) begin
          axi_resp.r_valid = 1'b1;
          axi_resp.r.data  = r_data_v;
          axi_resp.r.resp  = r_resp_v;
          axi_resp.r.last  = !r_last_bad;
          if (axi_req.r_ready) r_pend = 0;
        end else r_cnt++;
      end else axi_resp.r_valid = 1'b0;
      // a valid that saw no ready last cycle must still be up
      if (aw_wait) check("aw_valid_held", 64'(axi_req.aw_valid), 64'd1);
      if (w_wait)  check("w_valid_held", 64'(axi_req.w_valid), 64'd1);
      if (ar_wait) check("ar_valid_held", 64'(axi_req.ar_valid), 64'd1);
      aw_wait = 0; w_wait = 0; ar_wait = 0;
      // AW
      if (axi_req.aw_valid) begin
        if (aw_cnt >= aw_delay) begin
          axi_resp.aw_ready = 1'b1; cap_aw = axi_req.aw; aw_got = 1; aw_cnt = 0;
        end else begin
          axi_resp.aw_ready = 1'b0; aw_cnt++; aw_wait = 1;
        end
      end else begin
        axi_resp.aw_ready = 1'b0; aw_cnt = 0;
      end
      // W
      if (axi_req.w_valid) begin
        if (w_cnt >= w_delay) begin
          axi_resp.w_ready = 1'b1; cap_w = axi_req.w; w_got = 1; w_cnt = 0; w_beats++;
        end else begin
          axi_resp.w_ready = 1'b0; w_cnt++; w_wait = 1;
        end
      end else begin
        axi_resp.w_ready = 1'b0; w_cnt = 0;
      end
      // AR
      if (axi_req.ar_valid) begin
        if (ar_cnt >= ar_delay) begin
          axi_resp.ar_ready = 1'b1; cap_ar = axi_req.ar; ar_cnt = 0;
          r_pend = 1; r_cnt = 0;
          if (mapped(cap_ar.addr)) begin
            r_resp_v = RESP_OKAY;
            r_data_v = slv_mem.exists(cap_ar.addr[63:3]) ? slv_mem[cap_ar.addr[63:3]] : 64'd0;
          end else begin
            r_resp_v = RESP_DECERR;
            r_data_v = 64'd0;
          end
        end else begin
          axi_resp.ar_ready = 1'b0; ar_cnt++; ar_wait = 1;
        end
      end else begin
        axi_resp.ar_ready = 1'b0; ar_cnt = 0;
      end
      // both write halves accepted: commit and schedule B
      if (aw_got && w_got && !b_pend) begin
        if (mapped(cap_aw.addr)) begin
          slv_mem[cap_aw.addr[63:3]] = merge(slv_mem.exists(cap_aw.addr[63:3]) ?
                                             slv_mem[cap_aw.addr[63:3]] : 64'd0, cap_w.data, cap_w.strb);
          b_resp_v = RESP_OKAY;
        end else b_resp_v = RESP_DECERR;
        b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [63:0] model_mem [logic [60:0]];
  logic [63:0] last_rdata = 64'd0;

  function automatic logic [63:0] model_read(input logic [63:0] a);
    if (!mapped(a)) return 64'd0;
    return model_mem.exists(a[63:3]) ? model_mem[a[63:3]] : 64'd0;
  endfunction

  // One memory-port transaction; exp_lat < 0 skips the latency comparison
  task automatic access(input logic we, input logic [63:0] a, input logic [7:0] be,
                        input logic [63:0] wd, input int exp_lat);
    int n;
    int p0;
    int wb0;
    logic exp_err;
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; addr_i = a; be_i = be; wdata_i = wd;
    p0 = pulses; wb0 = w_beats;
    #1;
    n = 0;
    while (gnt_o !== 1'b1 && n < 50) begin @(negedge clk_i); #1; n++; end
    check("grant", 64'(gnt_o), 64'd1);
    @(negedge clk_i); #1;
    check("no_grant_busy", 64'(gnt_o), 64'd0);
    if (we) check("first_wr_valids", {62'd0, axi_req.aw_valid, axi_req.w_valid}, 64'd3);
    else    check("first_rd_valid", 64'(axi_req.ar_valid), 64'd1);
    req_i = 1'b0;
    n = 0;
    while (rvalid_o !== 1'b1 && n < 100) begin @(negedge clk_i); #1; n++; end
    check("rvalid", 64'(rvalid_o), 64'd1);
    if (exp_lat >= 0) check("latency", 64'(n), 64'(exp_lat));
    exp_err = !mapped(a) || (!we && r_last_bad);
    check("err", 64'(err_o), 64'(exp_err));
    if (we) begin
      if (mapped(a)) model_mem[a[63:3]] = merge(model_read(a), wd, be);
    end else last_rdata = model_read(a);
    check("rdata", rdata_o, last_rdata);
    if (we) begin
      check("aw_addr", cap_aw.addr, a);
      check("aw_len", 64'(cap_aw.len), 64'd0);
      check("aw_size", 64'(cap_aw.size), 64'd3);
      check("aw_burst", 64'(cap_aw.burst), 64'd1);
      check("aw_id", 64'(cap_aw.id), 64'd0);
      check("w_data", cap_w.data, wd);
      check("w_strb", 64'(cap_w.strb), 64'(be));
      check("w_last", 64'(cap_w.last), 64'd1);
    end else begin
      check("ar_addr", cap_ar.addr, a);
      check("ar_len", 64'(cap_ar.len), 64'd0);
      check("ar_size", 64'(cap_ar.size), 64'd3);
    end
    @(negedge clk_i); #1;
    check("rvalid_pulse", 64'(rvalid_o), 64'd0);
    check("one_completion", 64'(pulses - p0), 64'd1);
    if (we) check("one_w_beat", 64'(w_beats - wb0), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic        rw;
    logic [63:0] ra;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_valids", {59'd0, axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                         axi_req.b_ready, axi_req.r_ready}, 64'd0);
    rst_i = 1'b0;

    // full write then read-back, zero-wait slave
    access(1'b1, 64'h8000_0000, 8'hFF, 64'hDEADBEEF_CAFEF00D, 2);
    access(1'b0, 64'h8000_0000, 8'h00, 64'd0, 2);
    check("readback", rdata_o, 64'hDEADBEEF_CAFEF00D);

    // partial write keeps upper bytes
    access(1'b1, 64'h8000_0000, 8'h0F, 64'h11111111_22222222, 2);
    access(1'b0, 64'h8000_0000, 8'h00, 64'd0, 2);
    check("partial_readback", rdata_o, 64'hDEADBEEF_22222222);

    // AW stalled, then W stalled
    aw_delay = 3; w_delay = 0;
    access(1'b1, 64'h8000_0008, 8'hFF, 64'h0123_4567_89AB_CDEF, -1);
    aw_delay = 0; w_delay = 3;
    access(1'b1, 64'h8000_0010, 8'hF0, 64'hA5A5_A5A5_5A5A_5A5A, -1);
    w_delay = 0;
    access(1'b0, 64'h8000_0008, 8'h00, 64'd0, 2);
    check("aw_stall_readback", rdata_o, 64'h0123_4567_89AB_CDEF);

    // unmapped address: DECERR, then normal operation resumes
    access(1'b1, 64'h0000_0000_0000_FFF0, 8'hFF, 64'hFFFF_0000_FFFF_0000, -1);
    access(1'b0, 64'h0000_0000_0000_FFF0, 8'h00, 64'd0, -1);
    access(1'b0, 64'h8000_0010, 8'h00, 64'd0, 2);
    check("after_decerr_read", rdata_o, 64'hA5A5_A5A5_0000_0000);

    // read response without last flags an error
    r_last_bad = 1;
    access(1'b0, 64'h8000_0000, 8'h00, 64'd0, -1);
    r_last_bad = 0;

    // reset while waiting for R
    r_delay = 10;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = 64'h8000_0008;
    #1; check("rst_test_grant", 64'(gnt_o), 64'd1);
    @(negedge clk_i); req_i = 1'b0;
    #1; n = 0;
    while (axi_req.r_ready !== 1'b1 && n < 20) begin @(negedge clk_i); #1; n++; end
    check("in_wait_r", 64'(axi_req.r_ready), 64'd1);
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0; #1;
    check("midrst_valids", {59'd0, axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                            axi_req.b_ready, axi_req.r_ready}, 64'd0);
    check("midrst_rvalid", 64'(rvalid_o), 64'd0);
    check("midrst_rdata", rdata_o, 64'd0);
    last_rdata = 64'd0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 64'h8000_0000;
    #1; check("midrst_regrant", 64'(gnt_o), 64'd1);
    req_i = 1'b0;
    r_delay = 0;

    // randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      r_delay = $urandom_range(0, 3);
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ra = 64'h0000_0000_0000_FF00 + 64'(8 * $urandom_range(0, 3));
      else                           ra = 64'h8000_0000 + 64'(8 * $urandom_range(0, 7));
      access(rw, ra, 8'($urandom_range(0, 255)), {$urandom, $urandom}, -1);
    end

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem2axi_master.md
Name: mem2axi_master

Overview:
- Single-outstanding AXI4 initiator: converts a simple req/gnt memory port (req/we/addr/be/wdata, rvalid/rdata) into single-beat AXI4 transactions.
- Counterpart of axi2mem. Lets a core-side or test-side memory port drive a slave port of the ariane_soc AXI crossbar, e.g. to reach DRAM or the Accelerator.
- Bench use: drives the crossbar slave port into test_ram_64 through axi2mem.

Parameters:
- AXI_ADDR_WIDTH, 64, address width of the memory port and of AW/AR.
- AXI_DATA_WIDTH, 64, data width; the byte-enable width is AXI_DATA_WIDTH/8.
- AXI_ID_WIDTH, 4, ID width of the master side.
- AXI_USER_WIDTH, 64, user width; aw_user and ar_user are driven with '0.
- AXI_ID, 0, fixed ID placed on every AW and AR.
- axi_req_t, type, AXI request struct (aw/w/ar channels, b_ready, r_ready).
- axi_resp_t, type, AXI response struct (ready signals, b/r channels).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  memory request valid.
- gnt_o  out  1  request accepted this cycle.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  AXI_ADDR_WIDTH  byte address.
- be_i  in  AXI_DATA_WIDTH/8  byte enables, used for writes.
- wdata_i  in  AXI_DATA_WIDTH  write data.
- rvalid_o  out  1  one-cycle pulse: transaction complete.
- rdata_o  out  AXI_DATA_WIDTH  read data, valid with rvalid_o.
- err_o  out  1  error flag, valid with rvalid_o.
- axi_req_o  out  axi_req_t  AXI master request.
- axi_resp_i  in  axi_resp_t  AXI master response.

Behaviour:
- Reset (sync, active-high):
  - state = IDLE.
  - gnt_o, rvalid_o, err_o = 0; rdata_o = '0.
  - All AXI valid and ready outputs = 0.
  - Reset mid-transaction abandons it immediately. It is legal only together with a system-wide reset of the slaves.
- FSM states: IDLE, WR (AW and W in flight), WAIT_B, RD (AR in flight), WAIT_R.
- IDLE:
  - gnt_o = req_i, combinational.
  - On req_i, register addr, we, be and wdata. Next state is WR if we_i = 1, otherwise RD.
  - No other state asserts gnt_o. Requests outside IDLE are held by the requester.
- AW/AR fields:
  - addr = registered address, unmodified.
  - len = 0, size = $clog2(AXI_DATA_WIDTH/8), burst = INCR, id = AXI_ID.
  - cache = 0, prot = 0, qos = 0, region = 0, lock = 0, atop = 0.
- WR:
  - aw_valid and w_valid both assert in the first WR cycle, which is 1 cycle after the grant.
  - W fields: w.data = wdata, w.strb = be, w.last = 1.
  - Each valid drops after its own handshake. Per-channel done flags handle AW and W completing in either order or in the same cycle.
  - When both are done, go to WAIT_B.
  - AXI rule: a valid is never withdrawn before its ready.
- WAIT_B:
  - b_ready = 1.
  - On b_valid: pulse rvalid_o for 1 cycle, err_o = b.resp[1] (SLVERR/DECERR), then go to IDLE.
- RD: ar_valid = 1 until ar_ready, then go to WAIT_R.
- WAIT_R:
  - r_ready = 1.
  - On r_valid: rdata_o = r.data (registered), err_o = r.resp[1] | ~r.last, pulse rvalid_o, then go to IDLE.
- rdata_o holds its last value between reads. A write completion does not change rdata_o.
- Response IDs are not checked (single outstanding). b_valid and r_valid are ignored outside WAIT_B and WAIT_R.
- Latency with zero-wait slaves: grant at cycle 0, AW/W/AR valid at cycle 1, response accepted at cycle 2 or later, rvalid_o on the cycle after the response handshake.
- Back-to-back: a new grant is possible in the cycle after rvalid_o.
- The address is not split or checked. Unaligned addresses pass through unmodified; the slave defines the behaviour.

Decomposition:
- Package mem2axi_pkg:
  - state enum.
  - Function computing axsize from the data width.
  - Helper typedefs for the AXI structs, built with the axi typedef macros, matching the crossbar slave-port widths.
- No sub-module; the FSM and holding registers are self-contained.
- An _intf wrapper mapping the structs onto AXI_BUS is optional and lives in the same file.

Test Plan:
- Write: addr 0x8000_0000, wdata 0xDEADBEEF_CAFEF00D, be 0xFF.
  - Expect AW addr 0x8000_0000, len 0, size 3; W strb 0xFF, last 1; B OKAY.
  - Then rvalid_o pulses for 1 cycle with err_o = 0.
- Read back 0x8000_0000 through axi2mem + test_ram_64 → rdata_o = 0xDEADBEEF_CAFEF00D, err_o = 0.
- Partial write: be 0x0F, wdata 0x11111111_22222222 over existing 0xDEADBEEF_CAFEF00D → read gives 0xDEADBEEF_22222222.
- Handshake ordering, with the slave stalling aw_ready 3 cycles and w_ready 0 cycles, then the reverse:
  - AW and W each held until their own ready.
  - Exactly one W beat is sent.
  - Exactly one completion pulse.
- Unmapped address 0x0000_0000_0000_FFF0: the crossbar returns DECERR → rvalid_o = 1, err_o = 1, then the FSM is back in IDLE and accepts the next request.
- Assert rst_i while in WAIT_R for 1 cycle → the next cycle has all valids = 0, rvalid_o = 0, state IDLE, and req_i is granted immediately.
